eq_opp_sched: RTL and testbench

Parametrised N-channel equal-opportunity scheduler. Grants one channel at a time in round-robin order, for a programmable number of cycles per slot, and gates each channel's data input with its grant. Two modes: strict time-division (every channel gets its slot whether it requests or not) and work-conserving (idle channels are skipped). Sits between channel sources and a shared downstream resource.

---
 rtl/eq_opp_sched.sv | 107 ++++++++++
 tb/tb_eq_opp_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/eq_opp_sched.sv
// rtl/eq_opp_sched.sv - N-channel round-robin slot scheduler with strict-TDM and work-conserving modes
// Grants one channel per slot and gates each channel's data with its grant.
module eq_opp_sched #(
    parameter int             N        = 2,
    parameter int             SLOT_W   = 4,
    parameter logic [N-1:0]   INV_MASK = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SLOT_W-1:0]     slot_len,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          inp,
    output logic [N-1:0]          grant,
    output logic [N-1:0]          outp,
    output logic [$clog2(N)-1:0]  cur_ch,
    output logic                  slot_last,
    output logic                  wrap
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [SLOT_W-1:0] cnt_q, cnt_d;
    logic [SLOT_W-1:0] len_m1;
    logic              at_end;
    logic              found;
    logic [PTR_W-1:0]  hit;
    logic [PTR_W:0]    idx;
    logic              adv;
    logic [PTR_W-1:0]  nxt;

    // slot_len of 0 behaves as 1, so the final count is 0 in both cases
    always_comb begin
        len_m1 = (slot_len == '0) ? '0 : slot_len - SLOT_W'(1);
        at_end = (cnt_q >= len_m1);
    end

    // Scan from ptr+N down to ptr+1 so the nearest requester after ptr wins;
    // ptr itself (k = N) is therefore the last choice.
    always_comb begin
        found = 1'b0;
        hit   = ptr_q;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(N)) begin
                idx = idx - (PTR_W+1)'(N);
            end
            if (req[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                hit   = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        adv   = 1'b0;
        nxt   = ptr_q;
        if (en) begin
            if (!mode) begin
                if (at_end) begin
                    adv   = 1'b1;
                    nxt   = (ptr_q == PTR_W'(N-1)) ? '0 : ptr_q + PTR_W'(1);
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + SLOT_W'(1);
                end
            end else if (req[ptr_q] && !at_end) begin
                cnt_d = cnt_q + SLOT_W'(1);
            end else begin
                cnt_d = '0;
                if (found) begin
                    adv = 1'b1;
                    nxt = hit;
                end
            end
            ptr_d = nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = reset_n && en && (ptr_q == PTR_W'(i)) && (!mode || req[i]);
        end
    end

    assign outp      = grant & (inp ^ INV_MASK);
    assign cur_ch    = ptr_q;
    assign slot_last = en && at_end && (|grant);
    assign wrap      = reset_n && en && adv && (nxt <= ptr_q);

endmodule

// File: tb/tb_eq_opp_sched.sv
// tb/tb_eq_opp_sched.sv - directed self-checking bench for eq_opp_sched
module tb_eq_opp_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       en, mode;
    logic [3:0] slot_len, req, inp;
    logic [3:0] grant, outp;
    logic [1:0] cur_ch;
    logic       slot_last, wrap;

    logic       en2, mode2;
    logic [3:0] slot_len2;
    logic [1:0] req2, inp2, grant2, outp2;
    logic [0:0] cur_ch2;
    logic       slot_last2, wrap2;

    int checks = 0;
    int errors = 0;

    logic [3:0] wc_g [0:8] = '{4'h0, 4'h2, 4'h2, 4'h8, 4'h8, 4'h2, 4'h2, 4'h8, 4'h8};
    logic [8:0] wc_w = 9'b1_0001_0000;
    logic [1:0] t5_g [0:3] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] t5_o [0:3] = '{2'b01, 2'b00, 2'b01, 2'b00};

    eq_opp_sched #(.N(4), .SLOT_W(4), .INV_MASK(4'b0000)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .slot_len(slot_len),
        .req(req), .inp(inp), .grant(grant), .outp(outp), .cur_ch(cur_ch),
        .slot_last(slot_last), .wrap(wrap)
    );

    eq_opp_sched #(.N(2), .SLOT_W(4), .INV_MASK(2'b01)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en2), .mode(mode2), .slot_len(slot_len2),
        .req(req2), .inp(inp2), .grant(grant2), .outp(outp2), .cur_ch(cur_ch2),
        .slot_last(slot_last2), .wrap(wrap2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [3:0] e;
        reset_n = 1'b0; en = 1'b1; mode = 1'b0; slot_len = 4'd2; req = 4'hF; inp = 4'hF;
        en2 = 1'b1; mode2 = 1'b0; slot_len2 = 4'd0; req2 = 2'b00; inp2 = 2'b00;

        // reset held for 3 edges
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_grant", 8'(grant), 8'h00);
            chk("rst_outp", 8'(outp), 8'h00);
            chk("rst_cur_ch", 8'(cur_ch), 8'h00);
            chk("rst_wrap", 8'(wrap), 8'h00);
        end
        reset_n = 1'b1;
        #1;
        chk("rel_c1_grant", 8'(grant), 8'h01);
        chk("rel_c1_outp", 8'(outp), 8'h01);
        tick();
        chk("rel_c2_grant", 8'(grant), 8'h01);
        chk("rel_c2_slot_last", 8'(slot_last), 8'h01);
        tick();
        chk("rel_c3_grant", 8'(grant), 8'h02);

        // strict TDM, L = 3
        mode = 1'b0; slot_len = 4'd3; req = 4'h0; inp = 4'b0101;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            e = 4'(1 << ((c - 1) / 3));
            chk("tdm_grant", 8'(grant), 8'(e));
            chk("tdm_outp", 8'(outp), 8'(e & 4'b0101));
            chk("tdm_slot_last", 8'(slot_last), 8'((c % 3) == 0));
            chk("tdm_wrap", 8'(wrap), 8'(c == 12));
            tick();
        end
        chk("tdm_c13_grant", 8'(grant), 8'h01);

        // work-conserving, req = 1010
        mode = 1'b1; slot_len = 4'd2; req = 4'b1010; inp = 4'hF;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            chk("wc_grant", 8'(grant), 8'(wc_g[c]));
            chk("wc_wrap", 8'(wrap), 8'(wc_w[c]));
            tick();
        end

        // mid-slot drop and lone requester
        mode = 1'b1; slot_len = 4'd4; req = 4'b0100;
        do_reset();
        chk("drop_c1_grant", 8'(grant), 8'h00);
        tick();
        chk("drop_c2_grant", 8'(grant), 8'h04);
        tick();
        chk("drop_c3_grant", 8'(grant), 8'h04);
        tick();
        req = 4'b0000;
        #1;
        chk("drop_grant", 8'(grant), 8'h00);
        chk("drop_cur_ch", 8'(cur_ch), 8'h02);
        tick();
        chk("idle_cur_ch", 8'(cur_ch), 8'h02);
        chk("idle_wrap", 8'(wrap), 8'h00);
        tick();
        chk("idle2_cur_ch", 8'(cur_ch), 8'h02);
        req = 4'b0100;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("lone_grant", 8'(grant), 8'h04);
            chk("lone_wrap", 8'(wrap), 8'(k == 3));
            chk("lone_slot_last", 8'(slot_last), 8'(k == 3));
            tick();
        end

        // N = 2, slot_len 0, inverted channel 0
        do_reset();
        for (int c = 0; c < 4; c++) begin
            chk("n2_grant", 8'(grant2), 8'(t5_g[c]));
            chk("n2_outp", 8'(outp2), 8'(t5_o[c]));
            chk("n2_wrap", 8'(wrap2), 8'(c % 2));
            tick();
        end
        en2 = 1'b0;
        #1;
        chk("n2_dis_grant", 8'(grant2), 8'h00);
        chk("n2_dis_outp", 8'(outp2), 8'h00);
        chk("n2_dis_slot_last", 8'(slot_last2), 8'h00);
        tick();
        chk("n2_frozen_cur_ch", 8'(cur_ch2), 8'h00);
        tick();
        chk("n2_frozen2_cur_ch", 8'(cur_ch2), 8'h00);
        en2 = 1'b1;
        #1;
        chk("n2_resume_grant", 8'(grant2), 8'h01);

        // reset mid-slot at ptr 2, cnt 1
        mode = 1'b0; slot_len = 4'd3; req = 4'h0;
        do_reset();
        repeat (7) tick();
        chk("mid_pre_cur_ch", 8'(cur_ch), 8'h02);
        chk("mid_pre_grant", 8'(grant), 8'h04);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", 8'(grant), 8'h00);
        tick();
        reset_n = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("mid_cur_ch", 8'(cur_ch), 8'h00);
            chk("mid_grant", 8'(grant), 8'h01);
            tick();
        end
        chk("mid_next_grant", 8'(grant), 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
